// File: rtl/stim_sequencer_if.sv
// stim_sequencer_if: stimulus/response bundle between the sweep sequencer and the gate under test.
// The log member exists only when STIM_SEQUENCER_LOG_EN is defined.
interface stim_sequencer_if #(parameter int N = 2);
   logic           start;
   logic [1:0]     op;
   logic [N-1:0]   vec;
   logic           dut_y;
   logic           busy;
   logic           done;
   logic [N:0]     err_cnt;
   logic           pass;
`ifdef STIM_SEQUENCER_LOG_EN
   logic [2**N-1:0] log;
`endif
   modport master (
      input  start, op, dut_y,
      output vec, busy, done, err_cnt, pass
`ifdef STIM_SEQUENCER_LOG_EN
      , output log
`endif
   );
   modport slave (
      output start, op, dut_y,
      input  vec, busy, done, err_cnt, pass
`ifdef STIM_SEQUENCER_LOG_EN
      , input log
`endif
   );
endinterface

// File: rtl/stim_sequencer.sv
// stim_sequencer: sweeps every N-bit vector, holding each HOLD cycles, and counts gate-output mismatches.
// Optional per-vector response log enabled by STIM_SEQUENCER_LOG_EN.
module stim_sequencer #(
   parameter int N    = 2,
   parameter int HOLD = 10
) (
   input  logic               CLK,
   input  logic               RST_X,
   stim_sequencer_if.master   bus
);
   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
   state_t       r_state;
   logic [7:0]   r_cnt;
   logic [1:0]   r_op_q;
   logic [N-1:0] r_vec;
   logic [N:0]   r_err_cnt;
   logic         r_busy, r_done, r_pass;
   logic         w_exp, w_sample;
   logic [N:0]   w_err_nxt;
   always_comb begin
      w_exp     = r_op_q == 2'd0 ? &r_vec :
                  r_op_q == 2'd1 ? |r_vec :
                  r_op_q == 2'd2 ? ^r_vec : ~&r_vec;
      w_sample  = r_state == RUN && r_cnt == 8'(HOLD - 1);
      w_err_nxt = r_err_cnt + (N+1)'(bus.dut_y != w_exp);
   end
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_op_q    <= '0;
         r_vec     <= '0;
         r_err_cnt <= '0;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_pass    <= 1'b0;
      end else if (r_state != RUN) begin
         if (bus.start) begin
            r_state   <= RUN;
            r_cnt     <= '0;
            r_op_q    <= bus.op;
            r_vec     <= '0;
            r_err_cnt <= '0;
            r_busy    <= 1'b1;
            r_done    <= 1'b0;
            r_pass    <= 1'b0;
         end
      end else if (w_sample) begin
         r_err_cnt <= w_err_nxt;
         r_cnt     <= '0;
         // the last vector stays on the bus while DONE is reported
         if (&r_vec) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_pass  <= w_err_nxt == '0;
         end else begin
            r_vec <= r_vec + 1'b1;
         end
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end
`ifdef STIM_SEQUENCER_LOG_EN
   logic [2**N-1:0] r_log;
   always_ff @(posedge CLK or negedge RST_X) begin
      if (!RST_X)
         r_log <= '0;
      else if (r_state != RUN && bus.start)
         r_log <= '0;
      else if (w_sample)
         r_log[r_vec] <= bus.dut_y;
   end
   assign bus.log = r_log;
`endif
   assign bus.vec     = r_vec;
   assign bus.busy    = r_busy;
   assign bus.done    = r_done;
   assign bus.err_cnt = r_err_cnt;
   assign bus.pass    = r_pass;
endmodule

// File: tb/tb_stim_sequencer.sv
// tb_stim_sequencer: two sequencers (HOLD=10 and HOLD=1) share a truth-table gate model;
// every cycle is checked against sweep expectations derived from elapsed cycles.
module tb_stim_sequencer;
   logic       CLK = 1'b0;
   logic       RST_X = 1'b1;
   logic [3:0] tt = '0;
   logic [1:0] op = '0;
   logic       start_a = 1'b0, start_b = 1'b0;
   logic [3:0] log_a, log_b;
   int         n_vec = 0, n_miss = 0;

   stim_sequencer_if #(.N(2)) ba ();
   stim_sequencer_if #(.N(2)) bb ();

   stim_sequencer #(.N(2), .HOLD(10)) u_a (.CLK(CLK), .RST_X(RST_X), .bus(ba));
   stim_sequencer #(.N(2), .HOLD(1))  u_b (.CLK(CLK), .RST_X(RST_X), .bus(bb));

   assign ba.start = start_a;
   assign bb.start = start_b;
   assign ba.op    = op;
   assign bb.op    = op;
   assign ba.dut_y = tt[ba.vec];
   assign bb.dut_y = tt[bb.vec];
`ifdef STIM_SEQUENCER_LOG_EN
   assign log_a = ba.log;
   assign log_b = bb.log;
`else
   assign log_a = '0;
   assign log_b = '0;
`endif

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_miss++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic bit ref_fn(input logic [1:0] o, input int v);
      bit a = v[0], b = v[1];
      case (o)
         2'd0:    return a & b;
         2'd1:    return a | b;
         2'd2:    return a ^ b;
         default: return !(a & b);
      endcase
   endfunction

   // k = clock edges since the accepting edge; expectations follow from k/h alone
   task automatic check_inst(input string nm, input int h, input int k, input logic [1:0] o,
                             input logic [3:0] t, input logic [1:0] vec, input logic busy,
                             input logic done, input logic [2:0] err, input logic pass,
                             input logic [3:0] lg);
      int comp = (k / h > 4) ? 4 : k / h;
      int errs = 0;
      logic [3:0] exp_log = '0;
      bool_fin: begin end
      for (int v = 0; v < comp; v++) begin
         if (t[v] != ref_fn(o, v)) errs++;
         exp_log[v] = t[v];
      end
      chk({nm, "_vec"},  32'(vec),  k < 4*h ? 32'(k / h) : 32'd3);
      chk({nm, "_busy"}, 32'(busy), 32'(k < 4*h));
      chk({nm, "_done"}, 32'(done), 32'(k >= 4*h));
      chk({nm, "_err"},  32'(err),  32'(errs));
      chk({nm, "_pass"}, 32'(pass), 32'(k >= 4*h && errs == 0));
`ifdef STIM_SEQUENCER_LOG_EN
      chk({nm, "_log"},  32'(lg),   32'(exp_log));
`else
      chk({nm, "_log0"}, 32'(lg),   32'd0);
`endif
   endtask

   task automatic check_idle(input string tag);
      chk({tag, "_a"}, {ba.vec, ba.busy, ba.done, ba.err_cnt, ba.pass, log_a}, '0);
      chk({tag, "_b"}, {bb.vec, bb.busy, bb.done, bb.err_cnt, bb.pass, log_b}, '0);
   endtask

   task automatic sweep(input logic [1:0] o, input logic [3:0] t, input bit inject, input int abort_k);
      op = o; tt = t; start_a = 1'b1; start_b = 1'b1;
      @(posedge CLK); #1;
      start_a = 1'b0; start_b = 1'b0; op = 2'($urandom);
      for (int k = 0; k <= 42; k++) begin
         if (inject && k == 26) start_a = 1'b0;
         check_inst("a", 10, k, o, t, ba.vec, ba.busy, ba.done, ba.err_cnt, ba.pass, log_a);
         check_inst("b", 1,  k, o, t, bb.vec, bb.busy, bb.done, bb.err_cnt, bb.pass, log_b);
         if (k == abort_k) begin
            #2 RST_X = 1'b0;
            #1 check_idle("abort");
            @(negedge CLK) RST_X = 1'b1;
            return;
         end
         if (inject && k == 25) begin start_a = 1'b1; op = 2'd3; end
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #3 RST_X = 1'b0;
      #1 check_idle("reset");
      @(negedge CLK) RST_X = 1'b1;
      repeat (2) @(posedge CLK);
      #1 check_idle("idle");
      sweep(2'd0, 4'b1000, 1'b0, -1);
      sweep(2'd1, 4'b0000, 1'b0, -1);
      sweep(2'd0, 4'b1000, 1'b1, -1);
      sweep(2'd0, 4'b1001, 1'b0, 13);
      repeat (3) @(posedge CLK);
      #1 check_idle("post_abort");
      sweep(2'd0, 4'b1000, 1'b0, -1);
      sweep(2'd2, 4'b0110, 1'b0, -1);
      sweep(2'd3, 4'b0111, 1'b0, -1);
      for (int i = 0; i < 8; i++) sweep(2'($urandom), 4'($urandom), 1'b0, -1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/stim_sequencer.md
STIM_SEQUENCER -- requirements
Module: stim_sequencer

Interface
- REQ-001: Parameter N, default 2: width of the stimulus vector driven into the gate under test.
- REQ-002: Parameter HOLD, default 10: clock cycles each stimulus vector is held, legal range 1..255.
- REQ-003: Port CLK, input, 1 bit: single clock; all state updates on its rising edge.
- REQ-004: Port RST_X, input, 1 bit: reset, asynchronous and active-low.
- REQ-005: Port start, input, 1 bit: requests one full sweep; sampled only in IDLE or DONE.
- REQ-006: Port op, input, 2 bits: expected function (0 AND, 1 OR, 2 XOR, 3 NAND), each a reduction over vec.
- REQ-007: Port vec, output, N bits: stimulus vector to the gate under test.
- REQ-008: Port dut_y, input, 1 bit: gate-under-test result.
- REQ-009: Port busy, output, 1 bit: high in RUN.
- REQ-010: Port done, output, 1 bit: high in DONE.
- REQ-011: Port err_cnt, output, N+1 bits: mismatch count of the current or last sweep.
- REQ-012: Port pass, output, 1 bit: high in DONE when err_cnt==0, low otherwise.

Function
- REQ-013: FSM states are IDLE, RUN and DONE; there are no other states.
- REQ-014: In IDLE or DONE, a rising edge with start=1 SHALL enter RUN, set vec=0 and hold counter cnt=0, clear err_cnt, and latch op into op_q.
- REQ-015: In RUN, cnt SHALL increment each cycle from 0 to HOLD-1, so each vec value is held exactly HOLD cycles.
- REQ-016: At the edge where cnt==HOLD-1, dut_y SHALL be compared with the op_q reduction of vec, and err_cnt SHALL increment by 1 on mismatch.
- REQ-017: At that same edge, if vec is not all ones, vec SHALL increment and cnt SHALL return to 0; if vec is all ones, the FSM SHALL enter DONE and vec SHALL hold its value.
- REQ-018: done SHALL rise exactly 2^N*HOLD cycles after the start-accepting edge.
- REQ-019: start while in RUN SHALL be ignored, and op changes during RUN SHALL have no effect.
- REQ-020: DONE SHALL persist, with err_cnt and pass stable, until the next accepted start.
- REQ-021: err_cnt SHALL NOT wrap: its maximum value 2^N fits in N+1 bits.
- REQ-022: With HOLD=1, a new vector is applied and a sample is taken every cycle.

Reset
- REQ-023: When RST_X=0, regardless of CLK: state=IDLE, vec=0, cnt=0, err_cnt=0, op_q=0, busy=0, done=0, pass=0.
- REQ-024: Reset asserted mid-RUN SHALL abort the sweep with no residual count; after release, the block waits in IDLE for start.

Configuration
- REQ-025: Macro STIM_SEQUENCER_LOG_EN defined: the block adds output port log, 2^N bits wide; bit i holds the dut_y sampled for vector i; log clears to 0 on reset and on an accepted start.
- REQ-026: Macro not defined: the log port and its storage are absent, and all other behaviour is identical.

Verification
- REQ-027: N=2, HOLD=10, op=0, correct AND gate, start pulsed -> vec 0,1,2,3 for 10 cycles each; done rises 40 cycles after start; err_cnt=0; pass=1.
- REQ-028: op=1 (OR), dut_y tied 0 -> err_cnt=3, pass=0; with LOG_EN, log=4'b0000.
- REQ-029: start and op=3 pulsed at cnt=5 of vec=2 during an AND sweep -> sweep unaffected; done still rises 40 cycles after the original start.
- REQ-030: RST_X low at vec=1, cnt=3 with err_cnt=1 -> all outputs at reset values immediately; a new start after release gives a clean sweep with err_cnt=0.
- REQ-031: HOLD=1, op=2, correct XOR gate -> vec changes every cycle; done rises 4 cycles after start; pass=1; with LOG_EN, log=4'b0110.
- REQ-032: In DONE, start with op=3 and a NAND gate -> err_cnt clears on the accepting edge; second sweep ends with pass=1.
